// File: rtl/arb_grant_ctrl.sv
// Registered N-way grant controller: highest-index-first arbitration, frozen grant
// until release/withdrawal/hold timeout, one dead GAP cycle. Define ARB_RR_EN for round-robin.
module arb_grant_ctrl #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 15,
  parameter int HOLDW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, GNT, GAP} state_t;

  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state_q;
  logic [N-1:0]      gnt_q;
  logic [IDXW-1:0]   gnt_idx_q;
  logic              gnt_vld_q;
  logic              timeout_q;
  logic [HOLDW-1:0]  cnt_q;

  logic [IDXW-1:0]   win_idx;
  logic              owner_rel;
  logic              hold_exp;

  function automatic logic [IDXW-1:0] hi_idx(input logic [N-1:0] v);
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) hi_idx = IDXW'(i);
    end
  endfunction

`ifdef ARB_RR_EN
  logic [IDXW-1:0] ptr_q;
  logic [N-1:0]    rr_mask;
  logic [N-1:0]    req_lo;

  // Requesters below the last winner get first chance; fall back to the full set.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (IDXW'(i) < ptr_q) rr_mask[i] = 1'b1;
    end
    req_lo  = req & rr_mask;
    win_idx = (|req_lo) ? hi_idx(req_lo) : hi_idx(req);
  end
`else
  assign win_idx = hi_idx(req);
`endif

  assign owner_rel = done | ~req[gnt_idx_q];
  assign hold_exp  = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
`ifdef ARB_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            gnt_idx_q <= win_idx;
            gnt_vld_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= GNT;
`ifdef ARB_RR_EN
            ptr_q     <= win_idx;
`endif
          end
        end
        GNT: begin
          // A normal release outranks the hold limit in the same cycle.
          if (owner_rel || hold_exp) begin
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= ~owner_rel;
            state_q   <= GAP;
          end else if (cnt_q != HOLD_LAST) begin
            cnt_q <= cnt_q + HOLDW'(1);
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule
